// File: rtl/multicycle_control_pkg.sv
// ---------------------------------------------------------------------------
// multicycle_control_pkg
//   Shared encodings for the multicycle MIPS-style control unit: FSM state
//   encoding, opcode constants, datapath select codes, and an opcode
//   classifier used by both the decode and execute phases.
// ---------------------------------------------------------------------------
package multicycle_control_pkg;

   // FSM state encoding (also visible on the state output)
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_EXEC   = 3'd3,
      ST_MEM    = 3'd4,
      ST_WB     = 3'd5,
      ST_HALT   = 3'd6
   } state_t;

   // Opcodes (IR[31:26])
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_XORI  = 6'b001110;
   localparam logic [5:0] OP_LB    = 6'b100000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SB    = 6'b101000;
   localparam logic [5:0] OP_SW    = 6'b101011;

   // ALU operation codes (shared with the single-cycle control)
   localparam logic [2:0] ALU_OP_ADD   = 3'b000;
   localparam logic [2:0] ALU_OP_SLT   = 3'b001;
   localparam logic [2:0] ALU_OP_BEQ   = 3'b001;
   localparam logic [2:0] ALU_OP_AND   = 3'b010;
   localparam logic [2:0] ALU_OP_OR    = 3'b011;
   localparam logic [2:0] ALU_OP_XOR   = 3'b100;
   localparam logic [2:0] ALU_OP_BNE   = 3'b101;
   localparam logic [2:0] ALU_OP_RTYPE = 3'b111;

   // PC source select
   localparam logic [1:0] PC_SRC_ALU = 2'b00;
   localparam logic [1:0] PC_SRC_BTR = 2'b01;
   localparam logic [1:0] PC_SRC_JMP = 2'b10;

   // ALU B operand select
   localparam logic [1:0] ALUB_RT      = 2'b00;
   localparam logic [1:0] ALUB_FOUR    = 2'b01;
   localparam logic [1:0] ALUB_IMM     = 2'b10;
   localparam logic [1:0] ALUB_IMM_SH2 = 2'b11;

   // Register destination select
   localparam logic [1:0] RD_RT  = 2'b00;
   localparam logic [1:0] RD_RD  = 2'b01;
   localparam logic [1:0] RD_R31 = 2'b10;

   // Write-back source select
   localparam logic [1:0] WB_ALU = 2'b00;
   localparam logic [1:0] WB_MEM = 2'b01;
   localparam logic [1:0] WB_PC  = 2'b10;

   // Instruction classes driving the FSM path
   typedef enum logic [3:0] {
      CLS_R, CLS_J, CLS_JAL, CLS_BEQ, CLS_BNE,
      CLS_IALU, CLS_LOAD, CLS_STORE, CLS_ILL
   } op_class_t;

   function automatic op_class_t op_class(input logic [5:0] op);
      op_class_t c;
      c = CLS_ILL;
      case (op)
         OP_RTYPE:     c = CLS_R;
         OP_J:         c = CLS_J;
         OP_JAL:       c = CLS_JAL;
         OP_BEQ:       c = CLS_BEQ;
         OP_BNE:       c = CLS_BNE;
         OP_LB, OP_LW: c = CLS_LOAD;
         OP_SB, OP_SW: c = CLS_STORE;
         default: begin
            // addi..xori form a contiguous block; lui (001111) is not supported
            if (op >= OP_ADDI && op <= OP_XORI) c = CLS_IALU;
         end
      endcase
      return c;
   endfunction

   // ALU op for I-type ALU instructions, keyed on opcode[2:0]
   function automatic logic [2:0] ialu_op(input logic [2:0] f);
      logic [2:0] r;
      case (f)
         3'b000, 3'b001: r = ALU_OP_ADD;
         3'b010, 3'b011: r = ALU_OP_SLT;
         3'b100:         r = ALU_OP_AND;
         3'b101:         r = ALU_OP_OR;
         default:        r = ALU_OP_XOR;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/multicycle_control_wait_timer.sv
// ---------------------------------------------------------------------------
// mc_wait_timer
//   Counts consecutive cycles with mem_req=1 and mem_ready=0 and flags a
//   timeout in the cycle the count reaches TIMEOUT_CYCLES. A ready in that
//   same cycle suppresses the timeout so the access completes normally.
// Ports:
//   clk, rst_n  - clock, async active-low reset
//   mem_req     - access outstanding this cycle
//   mem_ready   - memory completes the access this cycle
//   clr         - FSM changes state at the next edge
//   timeout     - this cycle is the TIMEOUT_CYCLES-th stalled request cycle
// ---------------------------------------------------------------------------
module mc_wait_timer #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic mem_req,
   input  logic mem_ready,
   input  logic clr,
   output logic timeout
);
   localparam logic [7:0] LAST = 8'(TIMEOUT_CYCLES - 1);

   logic [7:0] cnt;   // stalled cycles already completed

   assign timeout = mem_req & ~mem_ready & (cnt == LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                        cnt <= '0;
      else if (clr | ~mem_req | mem_ready) cnt <= '0;
      else                               cnt <= cnt + 8'd1;
   end
endmodule

// File: rtl/multicycle_control.sv
// ---------------------------------------------------------------------------
// multicycle_control
//   FSM controller for a multicycle MIPS-style datapath:
//   IDLE -> FETCH -> DECODE -> {EXEC -> {MEM} -> {WB}} -> FETCH, with HALT on
//   an illegal opcode or a memory timeout (left only by reset).
//   Outputs are decoded from the state, except ir_write/pc_write which are
//   gated by mem_ready (fetch) and zero (branches).
// Ports:
//   clk, rst_n            - clock, async active-low reset
//   start                 - leave IDLE
//   opcode, zero          - IR[31:26] and ALU zero flag from the datapath
//   mem_ready             - memory access completes this cycle
//   mem_req/mem_we/iord   - memory strobes and address select
//   ir_write/pc_write/pc_src, alu_src_a/alu_src_b/alu_op,
//   reg_write/reg_dst/wb_sel - datapath controls
//   state, illegal, bus_err  - status (flags are sticky until reset)
//   cycle_cnt, instr_cnt     - perf counters, present only when
//                              MULTICYCLE_CTRL_PERF_EN is defined (else 0)
// ---------------------------------------------------------------------------
module multicycle_control
   import multicycle_control_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [5:0]  opcode,
   input  logic        zero,
   input  logic        mem_ready,
   output logic        mem_req,
   output logic        mem_we,
   output logic        iord,
   output logic        ir_write,
   output logic        pc_write,
   output logic [1:0]  pc_src,
   output logic        alu_src_a,
   output logic [1:0]  alu_src_b,
   output logic [2:0]  alu_op,
   output logic        reg_write,
   output logic [1:0]  reg_dst,
   output logic [1:0]  wb_sel,
   output logic [2:0]  state,
   output logic        illegal,
   output logic        bus_err,
   output logic [31:0] cycle_cnt,
   output logic [31:0] instr_cnt
);
   state_t     st, nxt;
   logic [5:0] op_q;
   op_class_t  cls_dec;   // live class while in DECODE
   op_class_t  cls_q;     // class of the registered opcode, EXEC onward
   logic       timeout;

   assign cls_dec = op_class(opcode);
   assign cls_q   = op_class(op_q);
   assign state   = st;

   mc_wait_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wait (
      .clk       (clk),
      .rst_n     (rst_n),
      .mem_req   (mem_req),
      .mem_ready (mem_ready),
      .clr       (nxt != st),
      .timeout   (timeout)
   );

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) st <= ST_IDLE;
      else        st <= nxt;
   end

   // opcode capture and sticky status
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q    <= '0;
         illegal <= 1'b0;
         bus_err <= 1'b0;
      end else begin
         if (st == ST_DECODE) op_q <= opcode;
         if (st == ST_DECODE && cls_dec == CLS_ILL) illegal <= 1'b1;
         if (timeout) bus_err <= 1'b1;
      end
   end

   // next state
   always_comb begin
      nxt = st;
      case (st)
         ST_IDLE:  if (start) nxt = ST_FETCH;
         ST_FETCH: begin
            if (timeout)        nxt = ST_HALT;
            else if (mem_ready) nxt = ST_DECODE;
         end
         ST_DECODE: begin
            case (cls_dec)
               CLS_J, CLS_JAL: nxt = ST_FETCH;
               CLS_ILL:        nxt = ST_HALT;
               default:        nxt = ST_EXEC;
            endcase
         end
         ST_EXEC: begin
            case (cls_q)
               CLS_R, CLS_IALU:     nxt = ST_WB;
               CLS_LOAD, CLS_STORE: nxt = ST_MEM;
               default:             nxt = ST_FETCH;
            endcase
         end
         ST_MEM: begin
            if (timeout)        nxt = ST_HALT;
            else if (mem_ready) nxt = (cls_q == CLS_STORE) ? ST_FETCH : ST_WB;
         end
         ST_WB:   nxt = ST_FETCH;
         default: nxt = ST_HALT;
      endcase
   end

   // outputs
   always_comb begin
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      iord      = 1'b0;
      ir_write  = 1'b0;
      pc_write  = 1'b0;
      pc_src    = PC_SRC_ALU;
      alu_src_a = 1'b0;
      alu_src_b = ALUB_RT;
      alu_op    = ALU_OP_ADD;
      reg_write = 1'b0;
      reg_dst   = RD_RT;
      wb_sel    = WB_ALU;
      case (st)
         ST_FETCH: begin
            // PC + 4 computed while the instruction is read
            mem_req   = 1'b1;
            alu_src_b = ALUB_FOUR;
            ir_write  = mem_ready;
            pc_write  = mem_ready;
         end
         ST_DECODE: begin
            // branch target = PC + (imm << 2), kept for a possible branch
            alu_src_b = ALUB_IMM_SH2;
            if (cls_dec == CLS_J || cls_dec == CLS_JAL) begin
               pc_write = 1'b1;
               pc_src   = PC_SRC_JMP;
            end
            if (cls_dec == CLS_JAL) begin
               reg_write = 1'b1;
               reg_dst   = RD_R31;
               wb_sel    = WB_PC;
            end
         end
         ST_EXEC: begin
            alu_src_a = 1'b1;
            case (cls_q)
               CLS_R:    alu_op = ALU_OP_RTYPE;
               CLS_IALU: begin
                  alu_src_b = ALUB_IMM;
                  alu_op    = ialu_op(op_q[2:0]);
               end
               CLS_BEQ: begin
                  alu_op   = ALU_OP_BEQ;
                  pc_write = zero;
                  pc_src   = PC_SRC_BTR;
               end
               CLS_BNE: begin
                  alu_op   = ALU_OP_BNE;
                  pc_write = ~zero;
                  pc_src   = PC_SRC_BTR;
               end
               default: alu_src_b = ALUB_IMM;   // load/store address
            endcase
         end
         ST_MEM: begin
            mem_req = 1'b1;
            iord    = 1'b1;
            mem_we  = (cls_q == CLS_STORE);
         end
         ST_WB: begin
            reg_write = 1'b1;
            if (cls_q == CLS_R)    reg_dst = RD_RD;
            if (cls_q == CLS_LOAD) wb_sel  = WB_MEM;
         end
         default: ;
      endcase
   end

`ifdef MULTICYCLE_CTRL_PERF_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cycle_cnt <= '0;
         instr_cnt <= '0;
      end else begin
         if (st != ST_IDLE && st != ST_HALT) cycle_cnt <= cycle_cnt + 32'd1;
         if (ir_write) instr_cnt <= instr_cnt + 32'd1;
      end
   end
`else
   assign cycle_cnt = '0;
   assign instr_cnt = '0;
`endif

endmodule
